cell_cache: RTL and testbench

- Double-buffered (ping-pong) frame store for HOG cells.
- Sits between the upstream cell builder, which writes masked-ready 768-bit cells in raster order, and cell_fetch, which reads them by address.
- Issues cell_fetch_start_o when a complete frame is resident.
- Read port has a fixed 2-cycle latency; cell_fetch's 2-deep skid FIFO is sized for this.

---
 rtl/cell_pkg.sv | 18 +
 rtl/cell_ram.sv | 41 ++++
 rtl/cell_cache.sv | 108 ++++++++++
 tb/tb_cell_cache.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cell_pkg.sv
// Shared constants for the HOG cell path: frame geometry, cell size,
// bank-state codes and the fixed read latency of the cell store.
package cell_pkg;

    localparam int FRAME_ROW_CNUM = 30;
    localparam int FRAME_COL_CNUM = 40;
    localparam int CELL_NUM       = FRAME_ROW_CNUM * FRAME_COL_CNUM;

    // 64 centre pixels plus 4x8 edge pixels, 8 bits each
    localparam int CELL_WIDTH     = (64 + 4 * 8) * 8;

    localparam logic [1:0] BANK_EMPTY = 2'd0;
    localparam logic [1:0] BANK_FULL  = 2'd1;
    localparam logic [1:0] BANK_BUSY  = 2'd2;

    localparam int RD_LATENCY = 2;

endpackage

// File: rtl/cell_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// address stage and a registered output stage (two-cycle read).
module cell_ram #(
    parameter int DATA_W = 768,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] addr_p1;
    logic              en_p1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // stage 1: capture address; stage 2: array read into the output register
    always_ff @(posedge clk) begin
        addr_p1 <= rd_addr;
        if (rst) begin
            en_p1   <= 1'b0;
            rd_data <= '0;
        end else begin
            en_p1 <= rd_en;
            if (en_p1) begin
                rd_data <= mem[addr_p1];
            end
        end
    end

endmodule

// File: rtl/cell_cache.sv
// Ping-pong frame store for HOG cells: the builder fills one bank while
// cell_fetch reads the other; a start pulse announces each complete frame.
module cell_cache #(
    parameter int   CELL_WIDTH  = cell_pkg::CELL_WIDTH,
    parameter int   CELL_NUM    = cell_pkg::CELL_NUM,
    localparam int  CELL_ADDR_W = $clog2(CELL_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CELL_WIDTH-1:0]  bwd_cell_data_i,
    input  logic                   bwd_cell_valid_i,
    output logic                   bwd_cell_ready_o,
    output logic                   cell_fetch_start_o,
    input  logic [CELL_ADDR_W-1:0] rd_cell_addr_i,
    input  logic                   rd_cell_vld_i,
    output logic [CELL_WIDTH-1:0]  rd_cell_data_o,
    output logic                   rd_cell_rdy_o
);

    import cell_pkg::*;

    localparam logic [CELL_ADDR_W-1:0] LAST_ADDR = CELL_ADDR_W'(CELL_NUM - 1);

    logic [1:0]             bank_state [2];
    logic                   wr_bank;
    logic                   rd_bank;
    logic                   rd_active;
    logic [CELL_ADDR_W-1:0] wr_cnt;
    logic [CELL_ADDR_W-1:0] rd_cnt;
    logic                   vld_p1;
    logic                   vld_p2;
    logic                   wr_acc;
    logic                   wr_last;
    logic                   rd_acc;
    logic                   rd_last;

    assign bwd_cell_ready_o   = (bank_state[wr_bank] == BANK_EMPTY);
    assign cell_fetch_start_o = (bank_state[rd_bank] == BANK_FULL) & ~rd_active;

    assign wr_acc  = bwd_cell_valid_i & bwd_cell_ready_o;
    assign wr_last = wr_acc & (wr_cnt == LAST_ADDR);
    assign rd_acc  = rd_cell_vld_i & rd_active;
    assign rd_last = rd_acc & (rd_cnt == LAST_ADDR);

    // Fill, start and release always touch different banks, so all three
    // updates may land in the same cycle without conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            rd_active     <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
        end else begin
            if (wr_acc) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
            end
            if (wr_last) begin
                bank_state[wr_bank] <= BANK_FULL;
                wr_bank             <= ~wr_bank;
            end
            if (cell_fetch_start_o) begin
                bank_state[rd_bank] <= BANK_BUSY;
                rd_active           <= 1'b1;
            end
            if (rd_acc) begin
                rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
            end
            if (rd_last) begin
                bank_state[rd_bank] <= BANK_EMPTY;
                rd_bank             <= ~rd_bank;
                rd_active           <= 1'b0;
            end
        end
    end

    // read valid pipeline, aligned with the RAM's address and output stages
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= rd_cell_vld_i;
            vld_p2 <= vld_p1;
        end
    end

    assign rd_cell_rdy_o = vld_p2;

    // The bank bit travels with the address, so reads still in flight after
    // a release keep returning data from the bank they were issued against.
    cell_ram #(
        .DATA_W (CELL_WIDTH),
        .ADDR_W (CELL_ADDR_W + 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr ({wr_bank, wr_cnt}),
        .wr_data (bwd_cell_data_i),
        .rd_en   (rd_cell_vld_i),
        .rd_addr ({rd_bank, rd_cell_addr_i}),
        .rd_data (rd_cell_data_o)
    );

endmodule

// File: tb/tb_cell_cache.sv
// Directed scoreboard bench for cell_cache with a 6-cell, 16-bit frame:
// reads push expected data and arrival cycle, a monitor pops on rdy.
module tb_cell_cache;

    localparam int CW = 16;
    localparam int CN = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic          start;
    logic [AW-1:0] raddr;
    logic          rvld;
    logic [CW-1:0] rdata;
    logic          rrdy;

    cell_cache #(
        .CELL_WIDTH (CW),
        .CELL_NUM   (CN)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bwd_cell_data_i    (wdata),
        .bwd_cell_valid_i   (wvalid),
        .bwd_cell_ready_o   (wready),
        .cell_fetch_start_o (start),
        .rd_cell_addr_i     (raddr),
        .rd_cell_vld_i      (rvld),
        .rd_cell_data_o     (rdata),
        .rd_cell_rdy_o      (rrdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int miss = 0;

    typedef struct {
        logic [CW-1:0] data;
        int            due;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every rdy must match the oldest outstanding read, on time
    exp_t e;
    always @(negedge clk) begin
        if (rrdy === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_rdy", 32'(rrdy), 32'd0);
            end else begin
                e = q.pop_front();
                check("rd_data", 32'(rdata), 32'(e.data));
                check("rd_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    logic          s_ready, s_start, s_rdy, s_acc;
    logic [CW-1:0] s_data;

    // one clock cycle of stimulus; outputs sampled at the falling edge
    task automatic drive(input logic wv, input logic [CW-1:0] wd, input logic rv,
                         input logic [AW-1:0] ra, input logic [CW-1:0] rexp,
                         input logic returns);
        wvalid = wv;
        wdata  = wd;
        rvld   = rv;
        raddr  = ra;
        if (rv && returns) q.push_back('{rexp, cyc + 2});
        @(negedge clk);
        s_ready = wready;
        s_start = start;
        s_rdy   = rrdy;
        s_data  = rdata;
        s_acc   = wv & wready;
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        rvld   = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [CW-1:0] d);
        drive(1'b1, d, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [CW-1:0] d);
        drive(1'b0, '0, 1'b1, a, d, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        wvalid = 1'b0;
        wdata  = '0;
        rvld   = 1'b0;
        raddr  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_ready", 32'(wready), 32'd1);
        check("reset_start", 32'(start), 32'd0);
        check("reset_rdy", 32'(rrdy), 32'd0);
        check("reset_data", 32'(rdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // frame 0 into bank 0, start one cycle after the last accept
        for (int i = 0; i < CN; i++) begin
            wr(CW'(i));
            check("f0_accept", 32'(s_acc), 32'd1);
            check("f0_no_start", 32'(s_start), 32'd0);
        end
        idle();
        check("f0_start", 32'(s_start), 32'd1);
        check("f0_ready_bank1", 32'(s_ready), 32'd1);

        // read frame 0 back-to-back
        for (int k = 0; k < CN; k++) begin
            rd(AW'(k), CW'(k));
            check("f0_rd_no_start", 32'(s_start), 32'd0);
        end
        idle();
        check("f0_released_no_start", 32'(s_start), 32'd0);
        check("f0_released_ready", 32'(s_ready), 32'd1);
        idle();
        idle();
        check("hold_rdy_low", 32'(s_rdy), 32'd0);
        check("hold_data", 32'(s_data), 32'h05);

        // frame 1 into bank 1, then frame 2 into bank 0 with no reads
        for (int i = 0; i < CN; i++) begin
            wr(CW'(16 + i));
            check("f1_accept", 32'(s_acc), 32'd1);
            check("f1_no_start", 32'(s_start), 32'd0);
        end
        for (int i = 0; i < CN; i++) begin
            wr(CW'(32 + i));
            check("f2_accept", 32'(s_acc), 32'd1);
            check("f2_start_first_only", 32'(s_start), (i == 0) ? 32'd1 : 32'd0);
        end

        // both banks occupied: writer stalls, frame 2 start withheld
        for (int i = 0; i < 3; i++) begin
            wr(CW'(48));
            check("stall_no_accept", 32'(s_acc), 32'd0);
            check("hold_start", 32'(s_start), 32'd0);
        end
        for (int k = 0; k < CN; k++) begin
            drive(1'b1, CW'(48), 1'b1, AW'(k), CW'(16 + k), 1'b1);
            check("stall_during_reads", 32'(s_acc), 32'd0);
            check("hold_start_reads", 32'(s_start), 32'd0);
        end
        wr(CW'(48));
        check("ready_after_release", 32'(s_acc), 32'd1);
        check("f2_start_after_release", 32'(s_start), 32'd1);

        // finish frame 3 in the same cycle as frame 2's last read
        rd(AW'(0), CW'(32));
        check("f2_rd0_no_start", 32'(s_start), 32'd0);
        for (int k = 1; k < CN; k++) begin
            drive(1'b1, CW'(48 + k), 1'b1, AW'(k), CW'(32 + k), 1'b1);
            check("f3_accept", 32'(s_acc), 32'd1);
            check("f3_no_start", 32'(s_start), 32'd0);
        end
        idle();
        check("f3_start_after_simul", 32'(s_start), 32'd1);
        check("f3_ready", 32'(s_ready), 32'd1);

        // partial frame 4 and frame 3 reads, then reset with reads in flight
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, CW'(64 + k), 1'b1, AW'(k), CW'(48 + k), 1'b1);
            check("f4_accept", 32'(s_acc), 32'd1);
            check("f4_no_start", 32'(s_start), 32'd0);
        end
        idle();
        drive(1'b0, '0, 1'b1, AW'(3), '0, 1'b0);
        rst = 1'b1;
        drive(1'b0, '0, 1'b1, AW'(4), '0, 1'b0);
        rst = 1'b0;
        idle();
        check("post_rst_rdy", 32'(s_rdy), 32'd0);
        check("post_rst_ready", 32'(s_ready), 32'd1);
        check("post_rst_start", 32'(s_start), 32'd0);
        check("post_rst_data", 32'(s_data), 32'd0);
        idle();
        check("post_rst_rdy2", 32'(s_rdy), 32'd0);
        check("post_rst_start2", 32'(s_start), 32'd0);

        // fresh frame 5 lands in bank 0 and reads back
        for (int i = 0; i < CN; i++) begin
            wr(CW'(80 + i));
            check("f5_accept", 32'(s_acc), 32'd1);
            check("f5_no_start", 32'(s_start), 32'd0);
        end
        idle();
        check("f5_start", 32'(s_start), 32'd1);
        for (int k = 0; k < CN; k++) begin
            rd(AW'(k), CW'(80 + k));
        end
        idle();
        idle();
        idle();
        check("f5_hold_rdy_low", 32'(s_rdy), 32'd0);
        check("f5_hold_data", 32'(s_data), 32'h55);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
